// File: rtl/alu_operand_sequencer.sv
// Byte-serial operand/opcode sequencer feeding the 8-bit ALU result register.
// Define ALU_SEQ_FLAGS_EN to build the Z/C/N/V flag registers; otherwise flags read 0.
module alu_operand_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] res_d,
  output logic             res_en,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  // state   | meaning
  // LOAD_A  | idle, waiting for operand A
  // LOAD_B  | waiting for operand B
  // LOAD_OP | waiting for opcode byte
  // EXEC    | one-cycle execute, result registered on closing edge
  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, result;
  logic [2:0]       op_q;
  logic [WIDTH:0]   sum, diff;

  assign in_ready = (state != EXEC) && !abort;
  assign busy     = (state != LOAD_A);

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    result = '0;
    case (op_q)
      3'b000:  result = sum[WIDTH-1:0];
      3'b001:  result = diff[WIDTH-1:0];
      3'b010:  result = a_q & b_q;
      3'b011:  result = a_q | b_q;
      3'b100:  result = a_q ^ b_q;
      3'b101:  result = {a_q[WIDTH-2:0], 1'b0};
      3'b110:  result = {1'b0, a_q[WIDTH-1:1]};
      default: result = ~a_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= LOAD_A;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_d  <= '0;
      res_en <= 1'b0;
    end else begin
      res_en <= 1'b0;
      if (abort) begin
        // Abort beats any pending byte and any result still in EXEC.
        state <= LOAD_A;
        a_q   <= '0;
        b_q   <= '0;
        op_q  <= '0;
      end else begin
        case (state)
          LOAD_A: if (in_valid) begin
            a_q   <= in_data;
            state <= LOAD_B;
          end
          LOAD_B: if (in_valid) begin
            b_q   <= in_data;
            state <= LOAD_OP;
          end
          LOAD_OP: if (in_valid) begin
            op_q  <= in_data[2:0];
            state <= EXEC;
          end
          default: begin
            res_d  <= result;
            res_en <= 1'b1;
            state  <= LOAD_A;
          end
        endcase
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic c_nxt, v_nxt;

  always_comb begin
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (op_q)
      3'b000: begin
        c_nxt = sum[WIDTH];
        v_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b001: begin
        c_nxt = diff[WIDTH];
        v_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b101:  c_nxt = a_q[WIDTH-1];
      3'b110:  c_nxt = a_q[0];
      default: c_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (state == EXEC && !abort) begin
      flag_z <= (result == '0);
      flag_c <= c_nxt;
      flag_n <= result[WIDTH-1];
      flag_v <= v_nxt;
    end
  end
`else
  logic carry_unused;
  assign carry_unused = sum[WIDTH] ^ diff[WIDTH];
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

- Byte-serial front end for the 8-bit ALU datapath.
- Accepts operand A, operand B and an opcode one byte at a time over a valid/ready handshake, executes the operation, and emits a result byte with a one-cycle load strobe.
- Sits directly upstream of the result register: `res_d` and `res_en` drive that register's data and enable inputs.
- Status flags are produced alongside the result.

## Interface
- `WIDTH`, 8: datapath width in bits; applies to `in_data`, operands and `res_d`.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream byte available.
- `in_ready`  output  1  block accepts a byte this cycle.
- `in_data`  input  WIDTH  operand A, operand B or opcode, in that order; opcode uses bits [2:0].
- `abort`  input  1  synchronous discard of the partial transaction.
- `busy`  output  1  high whenever state is not LOAD_A.
- `res_d`  output  WIDTH  registered result; held until the next result.
- `res_en`  output  1  one-cycle strobe; `res_d` is valid in that cycle.
- `flag_z`, `flag_c`, `flag_n`, `flag_v`  output  1 each  registered flags, updated with `res_d`.

## Operation
- FSM states: LOAD_A → LOAD_B → LOAD_OP → EXEC → LOAD_A.
- A byte is accepted on any rising edge where `in_valid && in_ready`.
- `in_ready` = state is LOAD_A, LOAD_B or LOAD_OP, and `abort` is low. It is combinational.
- LOAD_A and LOAD_B: the accepted byte is stored into the A or B register, and the state advances.
- LOAD_OP: `in_data[2:0]` is stored, and the state advances to EXEC.
- EXEC: one cycle, no handshake. On its closing edge:
  - the result goes to `res_d`;
  - `res_en` is set to 1;
  - flags are updated;
  - the state returns to LOAD_A.
- `res_en` is low in every other cycle.
- Opcodes:
  - 000 ADD A+B
  - 001 SUB A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL A<<1
  - 110 SHR A>>1, logical
  - 111 NOT A
- Arithmetic: computed at WIDTH+1 bits; the result is truncated to WIDTH.
- Flags:
  - `flag_z` = (result == 0).
  - `flag_n` = result[WIDTH-1].
  - `flag_c`:
    - ADD: carry out.
    - SUB: borrow (A < B, unsigned).
    - SHL: A[WIDTH-1].
    - SHR: A[0].
    - Otherwise: 0.
  - `flag_v`:
    - ADD/SUB: two's-complement signed overflow.
    - Otherwise: 0.
- `abort` high in any state on a clock edge:
  - the state goes to LOAD_A and partial operands are discarded;
  - `res_d` and flags are unchanged;
  - during EXEC, the result is dropped and `res_en` stays low.
- Abort coinciding with `in_valid`: abort wins and no byte is accepted.
- Reset, asserted at any time, including mid-transaction:
  - state LOAD_A;
  - A, B and opcode registers 0;
  - `res_d` 0, `res_en` 0, all flags 0, `busy` 0.
  - `in_ready` is 1 once reset is released (if `abort` is low).

## Timing
- Opcode accepted at edge k: EXEC occupies cycle k..k+1, `res_en` is high in cycle k+1..k+2, and the downstream register captures at edge k+2.
- `in_ready` is low during EXEC only. It is high again in the same cycle `res_en` is high.
- A new operand A can be accepted in the `res_en` cycle.
- Minimum period is 4 cycles per operation when `in_valid` is held high.
- Upstream stalls (`in_valid` low) hold the current state indefinitely; there is no timeout.

## Configuration
- `ALU_SEQ_FLAGS_EN`
  - Defined: flag logic is compiled in, with behaviour as above.
  - Undefined: all four flag outputs are tied to 0 and the flag registers are removed.
  - `res_d`, `res_en`, handshake and FSM behaviour are identical in both builds. Ports are present in both.

## Test plan
- ADD 0x7F, 0x01, 000 → `res_d` 0x80, N=1, V=1, C=0, Z=0; `res_en` high exactly one cycle, 2 cycles after the opcode edge.
- ADD 0xFF, 0x01 → 0x00, Z=1, C=1, V=0. SUB 0x05, 0x07 → 0xFE, C=1, N=1, V=0.
- SHL 0x81 → 0x02, C=1. SHR 0x81 → 0x40, C=1. NOT 0x0F → 0xF0, N=1.
- Stall test: send A and B, hold `in_valid` low for 10 cycles, then send the opcode.
  - `busy` stays high throughout and the result is correct.
  - Pulse `abort` after A only, then send a full new A, B, op; the result reflects only the new bytes.
- Assert `reset_n` low during LOAD_OP and during EXEC:
  - all outputs read 0 and `res_en` never pulses;
  - after release, the first complete transaction computes correctly.
- Build without `ALU_SEQ_FLAGS_EN`, repeat ADD 0xFF, 0x01 → `res_d` 0x00, all flags 0.
